// File: rtl/fetch_pkg.sv
// ---------------------------------------------------------------------------
// fetch_pkg
// Shared types and constants for the instruction-fetch stage and its branch
// predictor.
//   bht_state_t : 2-bit saturating direction counter encoding
//   btb_entry_t : branch-target-buffer entry {valid, tag, target}
//   NOP_INSTR   : instruction word loaded into IF/ID for a bubble
//   PC_INC      : sequential PC increment (16-bit instructions)
//   bht_train() : saturating counter update
// ---------------------------------------------------------------------------
package fetch_pkg;

    typedef enum logic [1:0] {
        STRONG_NT = 2'b00,
        WEAK_NT   = 2'b01,
        WEAK_T    = 2'b10,
        STRONG_T  = 2'b11
    } bht_state_t;

    // Tag field is kept 16 bits wide so the struct does not depend on the
    // table size; unused upper tag bits are simply zero.
    typedef struct packed {
        logic        valid;
        logic [15:0] tag;
        logic [15:0] target;
    } btb_entry_t;

    localparam logic [15:0] NOP_INSTR = 16'h0000;
    localparam logic [15:0] PC_INC    = 16'd2;

    function automatic bht_state_t bht_train(input bht_state_t s, input logic taken);
        logic [1:0] v;
        v = s;
        if (taken)
            bht_train = (v == 2'b11) ? STRONG_T : bht_state_t'(v + 2'd1);
        else
            bht_train = (v == 2'b00) ? STRONG_NT : bht_state_t'(v - 2'd1);
    endfunction

endpackage

// File: rtl/fetch_unit_branch_predictor.sv
// ---------------------------------------------------------------------------
// branch_predictor
// Direct-mapped 2-bit BHT plus BTB. Lookup is purely combinational on the
// current PC; training is a synchronous write from branch resolution, so a
// lookup and an update at the same index in one cycle sees the old entry.
// Ports:
//   clk, rst_n         : clock, asynchronous active-low reset
//   i_lookup_pc        : PC being fetched
//   o_pred_taken       : BTB hit and counter in a taken state
//   o_pred_target      : BTB target when predicted taken, else 0
//   i_update_en        : train this cycle
//   i_update_pc        : PC of the resolved branch
//   i_actual_taken     : resolved direction
//   i_actual_target    : resolved taken target
// ---------------------------------------------------------------------------
module branch_predictor
    import fetch_pkg::*;
#(
    parameter int INDEX_BITS = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] i_lookup_pc,
    output logic        o_pred_taken,
    output logic [15:0] o_pred_target,
    input  logic        i_update_en,
    input  logic [15:0] i_update_pc,
    input  logic        i_actual_taken,
    input  logic [15:0] i_actual_target
);

    localparam int ENTRIES = 1 << INDEX_BITS;

    bht_state_t r_bht [ENTRIES];
    btb_entry_t r_btb [ENTRIES];

    logic [INDEX_BITS-1:0] w_lk_idx;
    logic [INDEX_BITS-1:0] w_up_idx;
    logic [1:0]            w_lk_ctr;
    btb_entry_t            w_lk_entry;
    logic                  w_hit;
    logic                  w_unused_lsb;

    // Bit 0 of a PC is always 0 for 16-bit instructions, so it is
    // skipped by the index; tag is everything above the index.
    function automatic logic [15:0] tag_of(input logic [15:0] pc);
        tag_of = pc >> (INDEX_BITS + 1);
    endfunction

    assign w_lk_idx     = i_lookup_pc[INDEX_BITS:1];
    assign w_up_idx     = i_update_pc[INDEX_BITS:1];
    assign w_unused_lsb = i_lookup_pc[0] ^ i_update_pc[0];

    always_comb begin
        w_lk_entry    = r_btb[w_lk_idx];
        w_lk_ctr      = r_bht[w_lk_idx];
        w_hit         = w_lk_entry.valid && (w_lk_entry.tag == tag_of(i_lookup_pc));
        o_pred_taken  = w_hit && w_lk_ctr[1];
        o_pred_target = o_pred_taken ? w_lk_entry.target : 16'h0000;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_bht[i] <= WEAK_NT;
                r_btb[i] <= '0;
            end
        end else if (i_update_en) begin
            r_bht[w_up_idx] <= bht_train(r_bht[w_up_idx], i_actual_taken);
            // A not-taken resolution leaves the BTB entry alone.
            if (i_actual_taken)
                r_btb[w_up_idx] <= '{valid: 1'b1, tag: tag_of(i_update_pc), target: i_actual_target};
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
// Instruction-fetch stage: owns the PC, drives the instruction memory
// address, and registers the fetched word into the IF/ID register.
// Build option: define BRANCH_PRED_EN to include the BHT/BTB predictor;
// without it every fetch predicts fall-through and update_* is ignored.
// Ports:
//   clk, rst_n           : clock, asynchronous active-low reset
//   stall                : hold PC and IF/ID
//   halt                 : HLT in IF/ID, freeze fetch permanently
//   mispredict/correct_pc: redirect request and its target
//   update_en/update_pc/actual_taken/actual_target : predictor training
//   imem_addr/imem_data  : combinational instruction memory read
//   ifid_*               : IF/ID register contents (valid=0 is a bubble)
//   halted               : fetch frozen until reset
// ---------------------------------------------------------------------------
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int          INDEX_BITS = 3,
    parameter logic [15:0] RESET_PC   = 16'h0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        halt,
    input  logic        mispredict,
    input  logic [15:0] correct_pc,
    input  logic        update_en,
    input  logic [15:0] update_pc,
    input  logic        actual_taken,
    input  logic [15:0] actual_target,
    output logic [15:0] imem_addr,
    input  logic [15:0] imem_data,
    output logic [15:0] ifid_instr,
    output logic [15:0] ifid_pc_plus2,
    output logic        ifid_pred_taken,
    output logic [15:0] ifid_pred_target,
    output logic        ifid_valid,
    output logic        halted
);

    logic [15:0] r_pc;
    logic        r_halted;
    logic [15:0] r_ifid_instr;
    logic [15:0] r_ifid_pc_plus2;
    logic        r_ifid_pred_taken;
    logic [15:0] r_ifid_pred_target;
    logic        r_ifid_valid;

    logic [15:0] w_pc_plus2;
    logic        w_pred_taken;
    logic [15:0] w_pred_target;
    logic [15:0] w_pred_next;
    logic        w_freeze;

`ifdef BRANCH_PRED_EN
    branch_predictor #(
        .INDEX_BITS (INDEX_BITS)
    ) u_bp (
        .clk             (clk),
        .rst_n           (rst_n),
        .i_lookup_pc     (r_pc),
        .o_pred_taken    (w_pred_taken),
        .o_pred_target   (w_pred_target),
        .i_update_en     (update_en),
        .i_update_pc     (update_pc),
        .i_actual_taken  (actual_taken),
        .i_actual_target (actual_target)
    );
`else
    logic w_unused_update;
    assign w_unused_update = ^{update_en, update_pc, actual_taken, actual_target};
    assign w_pred_taken    = 1'b0;
    assign w_pred_target   = 16'h0000;
`endif

    assign w_pc_plus2  = r_pc + PC_INC;
    assign w_pred_next = w_pred_taken ? w_pred_target : w_pc_plus2;
    // The incoming halt freezes fetch in the same cycle it is seen.
    assign w_freeze    = r_halted | halt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc               <= RESET_PC;
            r_halted           <= 1'b0;
            r_ifid_instr       <= NOP_INSTR;
            r_ifid_pc_plus2    <= 16'h0000;
            r_ifid_pred_taken  <= 1'b0;
            r_ifid_pred_target <= 16'h0000;
            r_ifid_valid       <= 1'b0;
        end else begin
            // A concurrent mispredict means the HLT was on the wrong path.
            if (halt && !mispredict)
                r_halted <= 1'b1;

            if (mispredict)
                r_pc <= correct_pc;
            else if (!w_freeze && !stall)
                r_pc <= w_pred_next;

            if (mispredict || w_freeze) begin
                r_ifid_instr       <= NOP_INSTR;
                r_ifid_pc_plus2    <= 16'h0000;
                r_ifid_pred_taken  <= 1'b0;
                r_ifid_pred_target <= 16'h0000;
                r_ifid_valid       <= 1'b0;
            end else if (!stall) begin
                r_ifid_instr       <= imem_data;
                r_ifid_pc_plus2    <= w_pc_plus2;
                r_ifid_pred_taken  <= w_pred_taken;
                r_ifid_pred_target <= w_pred_target;
                r_ifid_valid       <= 1'b1;
            end
        end
    end

    assign imem_addr        = r_pc;
    assign halted           = r_halted;
    assign ifid_instr       = r_ifid_instr;
    assign ifid_pc_plus2    = r_ifid_pc_plus2;
    assign ifid_pred_taken  = r_ifid_pred_taken;
    assign ifid_pred_target = r_ifid_pred_target;
    assign ifid_valid       = r_ifid_valid;

endmodule
